irq_pending_ctrl: RTL and testbench

- Interrupt front-end that sits directly upstream of the CPU's priority encoder.
- Edge-detects raw interrupt lines and holds them as pending bits. Applies the enable mask and drives the masked pending vector into the encoder.
- Captures the encoder's returned index and runs a req/ack/done handshake with the CPU interrupt sequencer. The serviced source's pending bit is cleared on ack.

---
 rtl/irq_pending_ctrl.sv | 166 ++++++++++++++++
 tb/tb_irq_pending_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
//   Interrupt front-end placed directly upstream of the CPU priority encoder.
//   Rising edges on the raw interrupt lines are latched as pending bits. The
//   enable mask is applied and the masked pending vector is driven to the
//   encoder. The encoder's returned index is captured and presented to the CPU
//   sequencer through a req/ack/done handshake. The serviced source's pending
//   bit is cleared when the request is acknowledged.
//
//   Optional build macro: IRQ_NEST_EN
//     When defined, a higher-index source that becomes visible while a handler
//     is in service pre-empts it. The interrupted id is saved on a small stack
//     and restored on irq_done.
//
// Parameters
//   NR_IRQ      number of interrupt sources (2..32)
//   ID_BITS     width of a source index, clog2(NR_IRQ)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   irq_in       raw interrupt lines (synchronous to clk), 0->1 is an event
//   irq_mask     per-source enable, 1 = enabled
//   pend_vector  pending & irq_mask, combinational, to encoder input_vector
//   enc_id       encoder result: highest set index of pend_vector
//   irq_req      registered request to the CPU
//   irq_id       registered index of the requested / serviced source
//   irq_ack      CPU accepts the request (honoured only in REQ)
//   irq_done     CPU handler finished (honoured only in SERVICE)
//   busy         high while in REQ or SERVICE
// ---------------------------------------------------------------------------
module irq_pending_ctrl #(
   parameter int NR_IRQ  = 4,
   parameter int ID_BITS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NR_IRQ-1:0]  irq_in,
   input  logic [NR_IRQ-1:0]  irq_mask,
   output logic [NR_IRQ-1:0]  pend_vector,
   input  logic [ID_BITS-1:0] enc_id,
   output logic               irq_req,
   output logic [ID_BITS-1:0] irq_id,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   logic [1:0]         r_state;
   logic [NR_IRQ-1:0]  r_irq_in_d;
   logic [NR_IRQ-1:0]  r_pending;
   logic               r_irq_req;
   logic [ID_BITS-1:0] r_irq_id;

   logic [NR_IRQ-1:0]  w_rise;
   logic [NR_IRQ-1:0]  w_clr;
   logic [NR_IRQ-1:0]  w_one;
   logic               w_any;
   logic               w_ack_ok;

   assign w_one    = NR_IRQ'(1);
   assign w_rise   = irq_in & ~r_irq_in_d;
   assign w_ack_ok = (r_state == S_REQ) && irq_ack;
   // One-hot clear of the acknowledged source; a simultaneous rise re-sets it
   // because the rise is OR-ed in after the clear.
   assign w_clr    = w_ack_ok ? (w_one << r_irq_id) : '0;

   assign pend_vector = r_pending & irq_mask;
   assign w_any       = |pend_vector;

   assign irq_req = r_irq_req;
   assign irq_id  = r_irq_id;
   assign busy    = (r_state != S_IDLE);

`ifdef IRQ_NEST_EN
   localparam int SPW = ID_BITS + 1;

   logic [SPW-1:0]     r_sp;
   logic [ID_BITS-1:0] r_stack [NR_IRQ];
   logic               w_nest;
   logic [ID_BITS-1:0] w_top_idx;
   logic [ID_BITS-1:0] w_push_idx;

   // Pre-emption only for a strictly higher index; ids on the stack therefore
   // strictly increase and the depth never exceeds NR_IRQ-1.
   assign w_nest     = (r_state == S_SERVICE) && !irq_done && w_any &&
                       (enc_id > r_irq_id);
   assign w_top_idx  = ID_BITS'(r_sp - SPW'(1));
   assign w_push_idx = ID_BITS'(r_sp);

   // Stack contents need no reset: r_sp alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_nest) begin
         r_stack[w_push_idx] <= r_irq_id;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_irq_in_d <= '0;
         r_pending  <= '0;
         r_irq_req  <= 1'b0;
         r_irq_id   <= '0;
`ifdef IRQ_NEST_EN
         r_sp       <= '0;
`endif
      end else begin
         r_irq_in_d <= irq_in;
         r_pending  <= (r_pending & ~w_clr) | w_rise;

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_irq_id  <= enc_id;
                  r_irq_req <= 1'b1;
                  r_state   <= S_REQ;
               end
            end

            S_REQ: begin
               // Request is held until acknowledged, never withdrawn.
               if (irq_ack) begin
                  r_irq_req <= 1'b0;
                  r_state   <= S_SERVICE;
               end
            end

            S_SERVICE: begin
`ifdef IRQ_NEST_EN
               // irq_done takes precedence over a pre-emption in the same
               // cycle; a still-visible higher source pre-empts on a later cycle.
               if (irq_done) begin
                  if (r_sp != '0) begin
                     r_irq_id <= r_stack[w_top_idx];
                     r_sp     <= r_sp - SPW'(1);
                  end else begin
                     r_state  <= S_IDLE;
                  end
               end else if (w_nest) begin
                  r_sp      <= r_sp + SPW'(1);
                  r_irq_id  <= enc_id;
                  r_irq_req <= 1'b1;
                  r_state   <= S_REQ;
               end
`else
               if (irq_done) begin
                  r_state <= S_IDLE;
               end
`endif
            end

            default: begin
               r_state   <= S_IDLE;
               r_irq_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

   localparam int NR  = 4;
   localparam int IDB = 2;

   logic           clk;
   logic           rst_n;
   logic [NR-1:0]  irq_in;
   logic [NR-1:0]  irq_mask;
   logic [NR-1:0]  pend_vector;
   logic [IDB-1:0] enc_id;
   logic           irq_req;
   logic [IDB-1:0] irq_id;
   logic           irq_ack;
   logic           irq_done;
   logic           busy;

   irq_pending_ctrl #(.NR_IRQ(NR), .ID_BITS(IDB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .pend_vector (pend_vector),
      .enc_id      (enc_id),
      .irq_req     (irq_req),
      .irq_id      (irq_id),
      .irq_ack     (irq_ack),
      .irq_done    (irq_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Priority encoder stand-in: highest set index of pend_vector.
   always_comb begin
      enc_id = '0;
      for (int i = 0; i < NR; i++) begin
         if (pend_vector[i]) enc_id = IDB'(i);
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic           req;
      logic [IDB-1:0] id;
      logic           busy;
      logic [NR-1:0]  pv;
   } exp_t;

   exp_t q[$];

   bit m_pend [NR];
   bit m_prev [NR];
   bit m_req;
   bit m_busy;
   int m_id;
   int m_stack[$];

   always @(posedge clk) begin : model
      exp_t e;
      int   top;
      int   clr_idx;
      bit   rise [NR];
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
         end
         m_req  = 0;
         m_busy = 0;
         m_id   = 0;
         m_stack.delete();
      end else begin
         top = -1;
         for (int i = 0; i < NR; i++) if (m_pend[i] && irq_mask[i]) top = i;
         for (int i = 0; i < NR; i++) rise[i] = irq_in[i] && !m_prev[i];
         clr_idx = -1;
         if (!m_busy) begin
            if (top >= 0) begin
               m_id = top; m_req = 1; m_busy = 1;
            end
         end else if (m_req) begin
            if (irq_ack) begin
               m_req = 0; clr_idx = m_id;
            end
         end else begin
            if (irq_done) begin
               if (m_stack.size() > 0) m_id = m_stack.pop_back();
               else m_busy = 0;
            end
`ifdef IRQ_NEST_EN
            else if (top > m_id) begin
               m_stack.push_back(m_id);
               m_id = top; m_req = 1;
            end
`endif
         end
         for (int i = 0; i < NR; i++) begin
            m_pend[i] = (m_pend[i] && (i != clr_idx)) || rise[i];
            m_prev[i] = irq_in[i];
         end
      end
      e.req  = m_req;
      e.id   = IDB'(m_id);
      e.busy = m_busy;
      for (int i = 0; i < NR; i++) e.pv[i] = m_pend[i] && irq_mask[i];
      q.push_back(e);
   end

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (q.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL sb_empty: no expectation queued at %0t", $time);
      end else begin
         e = q.pop_front();
         chk("irq_req",     32'(irq_req),     32'(e.req));
         chk("irq_id",      32'(irq_id),      32'(e.id));
         chk("busy",        32'(busy),        32'(e.busy));
         chk("pend_vector", 32'(pend_vector), 32'(e.pv));
      end
   end

   // ---------------- stimulus ----------------
   logic [NR-1:0] cur_in;
   logic [NR-1:0] cur_mask;

   task automatic drive(input logic ack, input logic dn);
      @(negedge clk);
      irq_in   = cur_in;
      irq_mask = cur_mask;
      irq_ack  = ack;
      irq_done = dn;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   task automatic wait_req(input int max);
      bit seen;
      seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         if (irq_req) seen = 1;
         else drive(1'b0, 1'b0);
      end
      if (!seen) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_req: irq_req not seen within %0d cycles", max);
      end
   endtask

   // Acts as the CPU sequencer: ack any request, finish handlers right away.
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) drive(irq_req, busy && !irq_req);
   endtask

   initial begin
      logic [NR-1:0] tg;
      logic          a;
      logic          d;
      rst_n    = 1'b0;
      irq_in   = '0;
      irq_mask = '0;
      irq_ack  = 1'b0;
      irq_done = 1'b0;
      cur_in   = '0;
      cur_mask = '1;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Single event on bit 1.
      cur_in = 4'b0010;
      wait_req(6);
      drive(1'b1, 1'b0);
      idle(2);
      drive(1'b0, 1'b1);
      cur_in = '0;
      idle(2);

      // Simultaneous edges on 0 and 3, back-to-back service.
      cur_in = 4'b1001;
      wait_req(6);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      wait_req(6);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      cur_in = '0;
      idle(2);

      // Masked source stays pending until unmasked.
      cur_mask = 4'b1011;
      cur_in   = 4'b0100;
      idle(20);
      cur_mask = 4'b1111;
      wait_req(6);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      cur_in = '0;
      idle(2);

      // New edge on bit 3 in the ack cycle of id 3.
      cur_in = 4'b1000;
      wait_req(6);
      cur_in = 4'b0000;
      drive(1'b0, 1'b0);
      cur_in = 4'b1000;
      drive(1'b1, 1'b0);
      idle(2);
      drive(1'b0, 1'b1);
      wait_req(6);
      drain(6);
      cur_in = '0;
      idle(2);

      // Higher source while servicing id 1.
      cur_in = 4'b0010;
      wait_req(6);
      drive(1'b1, 1'b0);
      idle(1);
      cur_in = 4'b1010;
      idle(3);
      drain(20);
      cur_in = '0;
      idle(2);

      // Asynchronous reset while in REQ with pending 1010.
      cur_in = 4'b1010;
      wait_req(6);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_irq_req",     32'(irq_req),     32'd0);
      chk("rst_irq_id",      32'(irq_id),      32'd0);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_pend_vector", 32'(pend_vector), 32'd0);
      cur_in = '0;
      irq_in = '0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      chk("post_rst_pend_vector", 32'(pend_vector), 32'd0);
      idle(2);

      // Randomised traffic with spurious ack/done and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         tg = '0;
         for (int b = 0; b < NR; b++) if ($urandom_range(0, 7) == 0) tg[b] = 1'b1;
         cur_in = cur_in ^ tg;
         if ($urandom_range(0, 31) == 0) cur_mask = NR'($urandom);
         if ($urandom_range(0, 15) == 0) cur_mask = '1;
         a = irq_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         d = (busy && !irq_req) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 599) == 0) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         drive(a, d);
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
